lsu_ctrl: RTL
=============

LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_MAX, default 32'h0000_0FFF, giving the highest legal byte address; addr above it faults.
REQ-002 clk  in  1  clock; all state SHALL change on posedge clk only.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 req  in  1  access request from the CPU; sampled only in IDLE.
REQ-005 op  in  3  operation: 0 LW, 1 LH, 2 LHU, 3 LB, 4 LBU, 5 SW, 6 SH, 7 SB.
REQ-006 addr  in  32  byte address of the access.
REQ-007 wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-008 pc  in  32  PC of the requesting instruction; latched with the request.
REQ-009 busy  out  1  high whenever state is not IDLE.
REQ-010 done  out  1  single-cycle completion pulse.
REQ-011 exc  out  1  high together with done when the access faulted.
REQ-012 rdata  out  32  extended load result; valid while done=1.
REQ-013 mem_addr  out  32  word address to memory, {addr[31:2],2'b00}.
REQ-014 mem_be  out  4  byte write enables to memory; bit i writes mem_wd[8i+7:8i].
REQ-015 mem_wd  out  32  store data replicated into the addressed lane(s).
REQ-016 mem_rd  in  32  combinational read word from memory at mem_addr.

Function
REQ-017 FSM states SHALL be IDLE, ACCESS, RESP, FAULT.
REQ-018 IDLE with req=1 and a legal access SHALL latch op, addr, wdata and pc, then go to ACCESS. Any other IDLE condition SHALL stay in IDLE.
REQ-019 An access SHALL be illegal if any of these hold, and IDLE SHALL then go to FAULT instead:
  - word op with addr[1:0]!=0;
  - half op with addr[0]!=0;
  - addr > ADDR_MAX.
REQ-020 ACCESS SHALL last exactly one cycle and drive mem_addr and mem_wd from the latched values.
REQ-021 In ACCESS, mem_be SHALL be:
  - 4'b1111 for SW;
  - 4'b0011 << addr[1:0] for SH;
  - 4'b0001 << addr[1:0] for SB;
  - 4'b0000 for loads.
REQ-022 In ACCESS, loads SHALL register the selected lane of mem_rd; ACCESS SHALL then go to RESP.
REQ-023 RESP SHALL assert done=1 and exc=0, then return to IDLE. Latency is req accepted at edge N, ACCESS cycle N+1, done cycle N+2.
REQ-024 FAULT SHALL assert done=1 and exc=1 for one cycle, then return to IDLE. A faulting access SHALL never assert mem_be.
REQ-025 rdata extension rules:
  - LB and LH SHALL sign-extend; LBU and LHU SHALL zero-extend; LW passes the word through.
  - rdata SHALL be 0 for stores and faults.
REQ-026 mem_be SHALL be 4'b0000 in every state other than ACCESS.
REQ-027 req while busy=1 SHALL be ignored. A new request SHALL be accepted no earlier than the cycle after done.
REQ-028 mem_wd replication: SB uses {4{wdata[7:0]}}, SH uses {2{wdata[15:0]}}, SW uses wdata.
REQ-029 On each store, the block SHALL print one simulation-only line in the ACCESS cycle: "@%h: *%h <= %h" with latched pc, mem_addr and the merged stored word.

Reset
REQ-030 reset=1 at a posedge SHALL force IDLE and clear all latched registers.
REQ-031 After reset: busy=0, done=0, exc=0, rdata=0, mem_be=0, mem_addr=0, mem_wd=0.
REQ-032 Reset asserted during ACCESS SHALL abort the access: mem_be is 0 from the reset edge onward and no done is produced.
REQ-033 If reset and req are high in the same cycle, reset SHALL win and the request SHALL be dropped.

Structure
REQ-034 Op encodings (LW..SB) and the state encoding SHALL live in a shared package, lsu_pkg, reused by the CPU decoder.
REQ-035 Lane selection and extension SHALL live in one combinational sub-module, lsu_ext, instanced once. The FSM SHALL stay in lsu_ctrl.

Verification
REQ-036 SW check: SW addr=0x10, wdata=0xDEADBEEF.
  - cycle N+1: mem_be=4'b1111, mem_addr=0x10;
  - cycle N+2: done=1, exc=0.
REQ-037 SB check: SB addr=0x13, wdata=0x000000A5 -> mem_be=4'b1000, mem_wd=0xA5A5A5A5.
REQ-038 Load check, with mem_rd=0x80FF7F01 at addr 0x20:
  - LB addr=0x23 -> rdata=0xFFFFFF80;
  - LBU addr=0x23 -> rdata=0x00000080;
  - LH addr=0x22 -> rdata=0xFFFF80FF.
REQ-039 Fault check:
  - LW addr=0x02 -> done=1, exc=1 at cycle N+1, mem_be=0 throughout;
  - SH addr=0x1001 -> same response.
REQ-040 Busy and reset check:
  - req held high for 6 cycles with LW -> exactly two completions (done cycles N+2 and N+5);
  - reset asserted in an ACCESS cycle -> no done, busy=0 the next cycle.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared op/state encodings and byte-enable helper for the load/store unit
package lsu_pkg;
  typedef enum logic [2:0] {
    OP_LW  = 3'd0,
    OP_LH  = 3'd1,
    OP_LHU = 3'd2,
    OP_LB  = 3'd3,
    OP_LBU = 3'd4,
    OP_SW  = 3'd5,
    OP_SH  = 3'd6,
    OP_SB  = 3'd7
  } op_t;
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2,
    S_FAULT  = 2'd3
  } state_t;
  function automatic logic [3:0] be_of(input op_t o, input logic [1:0] off);
    return o == OP_SW ? 4'b1111 :
           o == OP_SH ? 4'(4'b0011 << off) :
           o == OP_SB ? 4'(4'b0001 << off) : 4'b0000;
  endfunction
endpackage

// File: rtl/lsu_ext.sv
// lsu_ext: selects the addressed lane of a read word and sign/zero-extends it
module lsu_ext
  import lsu_pkg::*;
(
  input  op_t         op,
  input  logic [1:0]  off,
  input  logic [31:0] word,
  output logic [31:0] val
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    val = op == OP_LW  ? word :
          op == OP_LH  ? {{16{h[15]}}, h} :
          op == OP_LHU ? {16'b0, h} :
          op == OP_LB  ? {{24{b[7]}}, b} :
          op == OP_LBU ? {24'b0, b} : 32'b0;
  end
endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: single-outstanding load/store FSM with alignment/range faulting
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter logic [31:0] ADDR_MAX = 32'h0000_0FFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [2:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] pc,
  output logic        busy,
  output logic        done,
  output logic        exc,
  output logic [31:0] rdata,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);
  state_t      state;
  op_t         op_in, op_q;
  logic [31:0] addr_q, wdata_q, pc_q, ext_val;
  logic        fault;
  always_comb begin
    op_in = op_t'(op);
    fault = ((op_in == OP_LW || op_in == OP_SW) && addr[1:0] != 2'b00) ||
            ((op_in == OP_LH || op_in == OP_LHU || op_in == OP_SH) && addr[0]) ||
            addr > ADDR_MAX;
    busy = state != S_IDLE;
    mem_addr = {addr_q[31:2], 2'b00};
    mem_wd = op_q == OP_SB ? {4{wdata_q[7:0]}} :
             op_q == OP_SH ? {2{wdata_q[15:0]}} : wdata_q;
  end
  lsu_ext u_ext (
    .op   (op_q),
    .off  (addr_q[1:0]),
    .word (mem_rd),
    .val  (ext_val)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      op_q    <= OP_LW;
      addr_q  <= '0;
      wdata_q <= '0;
      pc_q    <= '0;
      done    <= 1'b0;
      exc     <= 1'b0;
      rdata   <= '0;
      mem_be  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req && fault) begin
            state <= S_FAULT;
            done  <= 1'b1;
            exc   <= 1'b1;
          end else if (req) begin
            state   <= S_ACCESS;
            op_q    <= op_in;
            addr_q  <= addr;
            wdata_q <= wdata;
            pc_q    <= pc;
            mem_be  <= be_of(op_in, addr[1:0]);
          end
        end
        S_ACCESS: begin
          state  <= S_RESP;
          mem_be <= '0;
          rdata  <= ext_val;
          done   <= 1'b1;
        end
        default: begin
          state <= S_IDLE;
          done  <= 1'b0;
          exc   <= 1'b0;
          rdata <= '0;
        end
      endcase
    end
  end
`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset && state == S_ACCESS && mem_be != 4'b0000)
      $display("@%h: *%h <= %h", pc_q, mem_addr,
               {mem_be[3] ? mem_wd[31:24] : mem_rd[31:24],
                mem_be[2] ? mem_wd[23:16] : mem_rd[23:16],
                mem_be[1] ? mem_wd[15:8]  : mem_rd[15:8],
                mem_be[0] ? mem_wd[7:0]   : mem_rd[7:0]});
  end
`endif
endmodule
